// File: rtl/fir_sched_pkg.sv
// Shared types for the three-lane FIR scheduler: sample/result widths, group layout, lane masks.
package fir_sched_pkg;

   localparam int LANES = 3;

   typedef logic signed [15:0] sample_t;
   typedef logic signed [63:0] acc_t;
   typedef acc_t               group_t [LANES];
   typedef logic [1:0]         lane_idx_t;
   typedef logic [LANES-1:0]   lane_mask_t;

   localparam lane_mask_t FULL_MASK = '1;

   // Valid lanes are always packed from lane 0 upward, so the highest set bit ends the group.
   function automatic lane_idx_t last_lane(input lane_mask_t m);
      if (m[2]) return 2'd2;
      if (m[1]) return 2'd1;
      return 2'd0;
   endfunction

endpackage

// File: rtl/fir_sched_group_fifo.sv
// Synchronous FIFO of finished result groups plus their lane masks; the caller guarantees no overflow.
module fir_sched_group_fifo
   import fir_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  acc_t                   push_data_i [LANES],
   input  lane_mask_t             push_mask_i,
   input  logic                   pop_i,
   output acc_t                   head_o [LANES],
   output lane_mask_t             head_mask_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   group_t              mem_q      [DEPTH];
   lane_mask_t          mask_mem_q [DEPTH];
   logic [AW-1:0]       wr_q, rd_q;
   logic [AW:0]         cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i)  rd_q <= rd_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_q]      <= push_data_i;
         mask_mem_q[wr_q] <= push_mask_i;
      end
   end

   assign head_o      = mem_q[rd_q];
   assign head_mask_o = mask_mem_q[rd_q];
   assign count_o     = cnt_q;

endmodule

// File: rtl/fir_lane_scheduler.sv
// Packs a serial sample stream into 3-lane groups for the FIR bank and re-serializes results in order.
// Optional partial-group flush is built when FIR_SCHED_FLUSH_EN is defined.
module fir_lane_scheduler
   import fir_sched_pkg::*;
#(
   parameter int LAT   = 4,
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    s_valid,
   output logic    s_ready,
   input  sample_t s_data,
   output sample_t lane_din  [LANES],
   input  acc_t    lane_dout [LANES],
   output logic    m_valid,
   input  logic    m_ready,
   output acc_t    m_data
`ifdef FIR_SCHED_FLUSH_EN
   ,
   input  logic    flush
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   lane_idx_t     idx_q, idx_d, sidx_q, sidx_d;
   sample_t       pack_q [2];
   sample_t       pack_d [2];
   sample_t       issue_data [LANES];
   logic          accept, issue, credit_ok;
   logic [LAT:0]  tag_q;
   lane_mask_t    issue_mask, retire_mask;
   logic [CW-1:0] fifo_cnt;
   acc_t          head [LANES];
   lane_mask_t    head_mask;
   logic          fire, last, pop;
   int unsigned   inflight;

   // Packer and credit: tag_q[LAT] is the group whose results sit on lane_dout this cycle.
   always_comb begin
      inflight   = $countones(tag_q);
      credit_ok  = (inflight + 32'(fifo_cnt)) < 32'(DEPTH);
      s_ready    = (idx_q != 2'd2) || credit_ok;
      accept     = s_valid && s_ready;
      issue      = 1'b0;
      issue_mask = FULL_MASK;
      issue_data = '{default: '0};
      idx_d      = idx_q;
      pack_d     = pack_q;
      if (accept) begin
         if (idx_q == 2'd2) begin
            issue         = 1'b1;
            issue_data[0] = pack_q[0];
            issue_data[1] = pack_q[1];
            issue_data[2] = s_data;
            idx_d         = 2'd0;
         end else begin
            pack_d[idx_q[0]] = s_data;
            idx_d            = idx_q + 2'd1;
         end
      end
`ifdef FIR_SCHED_FLUSH_EN
      // A partial group still consumes a credit, so a flush without credit waits.
      if (flush && !issue && (idx_d != 2'd0) && credit_ok) begin
         issue         = 1'b1;
         issue_data[0] = pack_d[0];
         issue_data[1] = (idx_d == 2'd2) ? pack_d[1] : '0;
         issue_mask    = (idx_d == 2'd2) ? 3'b011 : 3'b001;
         idx_d         = 2'd0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         sidx_q <= '0;
         tag_q  <= '0;
         for (int l = 0; l < LANES; l++) lane_din[l] <= '0;
      end else begin
         idx_q  <= idx_d;
         sidx_q <= sidx_d;
         tag_q  <= {tag_q[LAT-1:0], issue};
         for (int l = 0; l < LANES; l++) lane_din[l] <= issue ? issue_data[l] : '0;
      end
   end

   always_ff @(posedge clk) begin
      pack_q <= pack_d;
   end

`ifdef FIR_SCHED_FLUSH_EN
   lane_mask_t mask_q [LAT+1];

   always_ff @(posedge clk) begin
      mask_q[0] <= issue_mask;
      for (int k = 1; k <= LAT; k++) mask_q[k] <= mask_q[k-1];
   end

   assign retire_mask = mask_q[LAT];
`else
   assign retire_mask = FULL_MASK;
`endif

   fir_sched_group_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (tag_q[LAT]),
      .push_data_i (lane_dout),
      .push_mask_i (retire_mask),
      .pop_i       (pop),
      .head_o      (head),
      .head_mask_o (head_mask),
      .count_o     (fifo_cnt)
   );

   // Serializer: walk the valid lanes of the head group, pop after the last one.
   always_comb begin
      m_valid = (fifo_cnt != '0);
      fire    = m_valid && m_ready;
      last    = (sidx_q == last_lane(head_mask));
      pop     = fire && last;
      sidx_d  = sidx_q;
      if (fire) sidx_d = last ? 2'd0 : sidx_q + 2'd1;
      m_data  = m_valid ? head[sidx_q] : '0;
   end

endmodule

// File: tb/tb_fir_lane_scheduler.sv
// Bench for fir_lane_scheduler: delay-line filter model, queue-based reference, directed and random traffic.
module tb_fir_lane_scheduler;
   import fir_sched_pkg::*;

   localparam int LAT   = 4;
   localparam int DEPTH = 4;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   logic    s_valid = 1'b0;
   logic    m_ready = 1'b0;
   sample_t s_data = '0;
   logic    s_ready, m_valid;
   sample_t lane_din  [LANES];
   acc_t    lane_dout [LANES];
   acc_t    m_data;
`ifdef FIR_SCHED_FLUSH_EN
   logic    flush = 1'b0;
`endif

   always #5 clk = ~clk;

   fir_lane_scheduler #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .lane_din  (lane_din),
      .lane_dout (lane_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data)
`ifdef FIR_SCHED_FLUSH_EN
      ,
      .flush     (flush)
`endif
   );

   // Filter bank stand-in: pure LAT-cycle delay with sign extension.
   sample_t dly [LAT][LANES];
   always @(posedge clk) begin
      dly[0] <= lane_din;
      for (int k = 1; k < LAT; k++) dly[k] <= dly[k-1];
   end
   always_comb begin
      for (int l = 0; l < LANES; l++) lane_dout[l] = acc_t'(dly[LAT-1][l]);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Reference model: expected result order, outstanding groups with their ready cycle.
   longint  exp_s[$];
   int      grp_rdy[$];
   int      grp_left[$];
   int      fill = 0;
   sample_t cur [LANES];
   sample_t exp_din [LANES];
   int      cyc = 0;
   int      first_mv = -1;
   longint  out_log[$];
   longint  in_log[$];
   int      acc_log[$];
   longint  want[$];
   bit      credit_m, exp_mv, issue_m;
   int      gn;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_s.delete();
         grp_rdy.delete();
         grp_left.delete();
         fill = 0;
         for (int l = 0; l < LANES; l++) exp_din[l] = '0;
      end else begin
         credit_m = grp_rdy.size() < DEPTH;
         exp_mv   = (grp_rdy.size() > 0) && (grp_rdy[0] <= cyc);
         check("s_ready", s_ready, (fill != 2) || credit_m);
         check("m_valid", m_valid, exp_mv);
         check("lane_din", {lane_din[0], lane_din[1], lane_din[2]},
               {exp_din[0], exp_din[1], exp_din[2]});
         if (m_valid && exp_mv) check("m_data", m_data, exp_s[0]);
         if (m_valid && first_mv < 0) first_mv = cyc;
         if (m_valid && m_ready) begin
            out_log.push_back(m_data);
            if (exp_mv) begin
               void'(exp_s.pop_front());
               grp_left[0]--;
               if (grp_left[0] == 0) begin
                  void'(grp_left.pop_front());
                  void'(grp_rdy.pop_front());
               end
            end
         end
         issue_m = 1'b0;
         gn      = 3;
         if (s_valid && s_ready) begin
            acc_log.push_back(cyc);
            in_log.push_back(s_data);
            exp_s.push_back(s_data);
            cur[fill] = s_data;
            fill++;
            if (fill == 3) begin
               issue_m = 1'b1;
               fill    = 0;
            end
         end
`ifdef FIR_SCHED_FLUSH_EN
         if (!issue_m && flush && fill > 0 && credit_m) begin
            issue_m = 1'b1;
            gn      = fill;
            for (int l = fill; l < LANES; l++) cur[l] = '0;
            fill = 0;
         end
`endif
         for (int l = 0; l < LANES; l++) exp_din[l] = issue_m ? cur[l] : '0;
         if (issue_m) begin
            grp_rdy.push_back(cyc + LAT + 2);
            grp_left.push_back(gn);
         end
         check("credit_bound", grp_rdy.size() <= DEPTH, 1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input longint v);
      int  n;
      bit  ok;
      n       = 0;
      s_valid = 1'b1;
      s_data  = sample_t'(v);
      do begin
         @(negedge clk);
         ok = s_ready;
         if (!ok) begin
            @(posedge clk);
            n++;
         end
      end while (!ok && n < 500);
      if (!ok) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (grp_rdy.size() > 0 && n < 2000) begin
         tick();
         n++;
      end
      check("drain_done", grp_rdy.size(), 0);
   endtask

   task automatic clear_logs();
      out_log.delete();
      in_log.delete();
      acc_log.delete();
      want.delete();
      first_mv = -1;
   endtask

   task automatic expect_outs(input string nm);
      check({nm, "_count"}, out_log.size(), want.size());
      for (int i = 0; i < want.size() && i < out_log.size(); i++) check(nm, out_log[i], want[i]);
   endtask

   initial begin
      int it;
      m_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_lane_din", {lane_din[0], lane_din[1], lane_din[2]}, 0);

      // 1: back-to-back stream, first result LAT+2 cycles after the third accept
      clear_logs();
      for (int i = 1; i <= 9; i++) send(i);
      drain();
      for (int i = 1; i <= 9; i++) want.push_back(i);
      expect_outs("t1_out");
      if (acc_log.size() >= 3) check("t1_latency", first_mv - acc_log[2], 6);

      // 2: full backpressure until credits run out
      clear_logs();
      m_ready = 1'b0;
      for (int i = 0; i < 14; i++) send(200 + i);
      s_valid = 1'b1;
      s_data  = 16'sd214;
      repeat (20) tick();
      check("t2_stall_ready", s_ready, 0);
      check("t2_stall_valid", m_valid, 1);
      check("t2_accepted", acc_log.size(), 14);
      check("t2_held_data", m_data, 200);
      m_ready = 1'b1;
      send(214);
      drain();
      for (int i = 0; i < 15; i++) want.push_back(200 + i);
      expect_outs("t2_out");

      // 3: idle gap inside a group
      clear_logs();
      send(7);
      send(-3);
      repeat (4) tick();
      check("t3_gap_valid", m_valid, 0);
      check("t3_gap_outs", out_log.size(), 0);
      send(5);
      drain();
      want.push_back(7);
      want.push_back(-3);
      want.push_back(5);
      expect_outs("t3_out");

      // 4: reset with two groups in flight
      clear_logs();
      for (int i = 0; i < 6; i++) send(50 + i);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t4_rst_valid", m_valid, 0);
      check("t4_rst_ready", s_ready, 1);
      send(100);
      send(101);
      send(102);
      drain();
      repeat (10) tick();
      for (int i = 100; i <= 102; i++) want.push_back(i);
      expect_outs("t4_out");

`ifdef FIR_SCHED_FLUSH_EN
      // 5: flush of a two-sample partial group
      clear_logs();
      send(8);
      send(9);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t5_flush_din", {lane_din[0], lane_din[1], lane_din[2]}, {16'sd8, 16'sd9, 16'sd0});
      send(10);
      send(11);
      send(12);
      check("t5_next_din", {lane_din[0], lane_din[1], lane_din[2]}, {16'sd10, 16'sd11, 16'sd12});
      drain();
      for (int i = 8; i <= 12; i++) want.push_back(i);
      expect_outs("t5_out");
`endif

      // 6: random valid/ready
      clear_logs();
      it = 0;
      while (in_log.size() < 3000 && it < 40000) begin
         s_valid = 1'(($urandom % 2));
         s_data  = sample_t'($urandom);
         m_ready = 1'(($urandom % 2));
`ifdef FIR_SCHED_FLUSH_EN
         flush   = ($urandom % 16) == 0;
`endif
         tick();
         it++;
      end
      check("t6_enough_samples", in_log.size() >= 3000, 1);
      s_valid = 1'b0;
      m_ready = 1'b1;
`ifdef FIR_SCHED_FLUSH_EN
      flush = 1'b0;
      drain();
      flush = 1'b1;
      tick();
      flush = 1'b0;
`endif
      drain();
      for (int i = 0; i < in_log.size() - fill; i++) want.push_back(in_log[i]);
      expect_outs("t6_out");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
